// File: rtl/apb_master_mux_pkg.sv
// Shared definitions for the APB master bridge: FSM encoding, default
// geometry and a helper for sizing the wait-state counter.
package apb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_e;

    localparam int DEF_NUM_SLAVES = 2;
    localparam int DEF_ADDR_W     = 5;
    localparam int DEF_DATA_W     = 32;
    localparam int DEF_TIMEOUT    = 16;

    // Counter must hold the value TIMEOUT; keep at least one bit when disabled.
    function automatic int cnt_width(input int timeout);
        return (timeout == 0) ? 1 : $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/apb_master_mux_if.sv
// Host request/response port plus the APB bus towards the slaves.
// The bridge uses the master modport; the slave side sees the mirror image.
interface apb_master_mux_if
    import apb_pkg::*;
#(
    parameter int NUM_SLAVES = DEF_NUM_SLAVES,
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W
);

    // Host side
    logic                         req_valid;
    logic                         req_ready;
    logic                         req_write;
    logic [ADDR_W-1:0]            req_addr;
    logic [DATA_W-1:0]            req_wdata;
    logic                         rsp_valid;
    logic [DATA_W-1:0]            rsp_rdata;
    logic                         rsp_err;

    // APB side
    logic [NUM_SLAVES-1:0]        psel;
    logic                         penable;
    logic                         pwrite;
    logic [ADDR_W-1:0]            paddr;
    logic [DATA_W-1:0]            pwdata;
    logic [NUM_SLAVES*DATA_W-1:0] prdata;
    logic [NUM_SLAVES-1:0]        pready;
    logic [NUM_SLAVES-1:0]        pslverr;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
        output psel, penable, pwrite, paddr, pwdata,
        input  prdata, pready, pslverr
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
        input  psel, penable, pwrite, paddr, pwdata,
        output prdata, pready, pslverr
    );

endinterface

// File: rtl/apb_master_mux_addr_decoder.sv
// Address decoder: the top SEL_W address bits pick a slave; indices at or
// beyond NUM_SLAVES select nothing and raise miss.
module apb_addr_decoder #(
    parameter int NUM_SLAVES = 2,
    parameter int ADDR_W     = 5
) (
    input  logic [ADDR_W-1:0]     addr,
    output logic [NUM_SLAVES-1:0] sel,
    output logic                  miss
);

    localparam int SEL_W = $clog2(NUM_SLAVES);

    logic [SEL_W-1:0] idx;

    assign idx = addr[ADDR_W-1 -: SEL_W];

    // One-hot select from the slave index; no bit set means decode miss.
    always_comb begin
        // NOTE: every output gets a default before any branch so no path leaves it unassigned and no latch is inferred.
        sel = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            sel[i] = (int'(idx) == i);
        end
        miss = ~|sel;
    end

endmodule

// File: rtl/apb_master_mux.sv
// APB master bridge: runs single host transfers as SETUP/ACCESS phases,
// selects one of NUM_SLAVES slaves and reports pslverr, decode miss and
// wait-state timeout on rsp_err.
module apb_master_mux
    import apb_pkg::*;
#(
    parameter int NUM_SLAVES = DEF_NUM_SLAVES,
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int TIMEOUT    = DEF_TIMEOUT
) (
    input  logic             pclk,
    input  logic             rst,
    apb_master_mux_if.master bus
);

    localparam int SEL_W = $clog2(NUM_SLAVES);
    localparam int CNT_W = cnt_width(TIMEOUT);

    state_e                state_q, state_d;
    logic [NUM_SLAVES-1:0] sel_q;
    logic [SEL_W-1:0]      idx_q;
    logic [CNT_W-1:0]      cnt_q;

    logic [NUM_SLAVES-1:0] dec_sel;
    logic                  dec_miss;
    logic                  accept;
    logic                  sel_ready;
    logic                  sel_err;
    logic [DATA_W-1:0]     sel_rdata;
    logic                  timeout_hit;

    apb_addr_decoder #(
        .NUM_SLAVES (NUM_SLAVES),
        .ADDR_W     (ADDR_W)
    ) u_decoder (
        .addr (bus.req_addr),
        .sel  (dec_sel),
        .miss (dec_miss)
    );

    assign accept = (state_q == ST_IDLE) && bus.req_valid;

    // Return path: only the addressed slave's ready/error/data are looked at.
    always_comb begin
        sel_ready = 1'b0;
        sel_err   = 1'b0;
        sel_rdata = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (int'(idx_q) == i) begin
                sel_ready = bus.pready[i];
                sel_err   = bus.pslverr[i];
                sel_rdata = bus.prdata[i*DATA_W +: DATA_W];
            end
        end
    end

    // Last permitted ACCESS cycle without pready; a late pready still wins.
    assign timeout_hit = (TIMEOUT != 0) && (int'(cnt_q) == TIMEOUT - 1) && !sel_ready;

    // Next-state logic and bus-phase outputs.
    always_comb begin
        state_d       = state_q;
        bus.req_ready = (state_q == ST_IDLE);
        bus.penable   = (state_q == ST_ACCESS);
        bus.psel      = (state_q == ST_IDLE) ? '0 : sel_q;
        case (state_q)
            ST_IDLE:   if (accept && !dec_miss) state_d = ST_SETUP;
            ST_SETUP:  state_d = ST_ACCESS;
            ST_ACCESS: if (sel_ready || timeout_hit) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge pclk or negedge rst) begin
        // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst) state_q <= ST_IDLE;
        else      state_q <= state_d;
    end

    // Request capture, wait-state counter and response registers.
    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) begin
            bus.pwrite    <= 1'b0;
            bus.paddr     <= '0;
            bus.pwdata    <= '0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_rdata <= '0;
            bus.rsp_err   <= 1'b0;
            sel_q         <= '0;
            idx_q         <= '0;
            cnt_q         <= '0;
        end else begin
            bus.rsp_valid <= 1'b0;
            if (accept) begin
                bus.pwrite <= bus.req_write;
                bus.paddr  <= bus.req_addr;
                bus.pwdata <= bus.req_wdata;
                sel_q      <= dec_sel;
                idx_q      <= bus.req_addr[ADDR_W-1 -: SEL_W];
                cnt_q      <= '0;
                if (dec_miss) begin
                    bus.rsp_valid <= 1'b1;
                    bus.rsp_err   <= 1'b1;
                    bus.rsp_rdata <= '0;
                end
            end
            if (state_q == ST_ACCESS) begin
                if (sel_ready) begin
                    bus.rsp_valid <= 1'b1;
                    bus.rsp_err   <= sel_err;
                    bus.rsp_rdata <= (!bus.pwrite && !sel_err) ? sel_rdata : '0;
                end else if (timeout_hit) begin
                    bus.rsp_valid <= 1'b1;
                    bus.rsp_err   <= 1'b1;
                    bus.rsp_rdata <= '0;
                end else begin
                    cnt_q <= cnt_q + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_apb_master_mux.sv
// Directed bench for apb_master_mux: a two-slave bridge with timeout 16
// and a three-slave bridge with timeout disabled share clock and reset.
// Expected responses are queued at issue time and compared when rsp_valid
// pulses, including latency measured in cycles from acceptance.
module tb_apb_master_mux;
    import apb_pkg::*;

    localparam int AW    = 5;
    localparam int DW    = 32;
    localparam int NEVER = 1_000_000;

    typedef struct {
        logic          err;
        logic [DW-1:0] rdata;
        int            issue_cyc;
        int            lat;
    } exp_t;

    logic  pclk;
    logic  rst;
    int    cyc      = 0;
    int    n_checks = 0;
    int    n_fail   = 0;
    int    last_issue;
    exp_t  sb[$];
    exp_t  sb3[$];
    int    wait_n[2];
    int    acc_cnt[2];
    logic [2:0] pready3;

    apb_master_mux_if #(.NUM_SLAVES(2), .ADDR_W(AW), .DATA_W(DW)) bus ();
    apb_master_mux_if #(.NUM_SLAVES(3), .ADDR_W(AW), .DATA_W(DW)) bus3 ();

    apb_master_mux #(.NUM_SLAVES(2), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(16)) dut (
        .pclk (pclk),
        .rst  (rst),
        .bus  (bus.master)
    );

    apb_master_mux #(.NUM_SLAVES(3), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(0)) dut3 (
        .pclk (pclk),
        .rst  (rst),
        .bus  (bus3.master)
    );

    initial begin
        pclk = 1'b0;
        forever #5 pclk = ~pclk;
    end

    always @(posedge pclk) cyc <= cyc + 1;

    // Slave model: slave i raises pready after wait_n[i] ACCESS cycles.
    always @(posedge pclk) begin
        for (int i = 0; i < 2; i++) begin
            if (bus.psel[i] === 1'b1 && bus.penable === 1'b1) acc_cnt[i] <= acc_cnt[i] + 1;
            else                                              acc_cnt[i] <= 0;
        end
    end

    always_comb begin
        for (int i = 0; i < 2; i++) bus.pready[i] = (acc_cnt[i] >= wait_n[i]);
    end

    assign bus3.pready = pready3;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Response monitor: every rsp_valid pulse must match the oldest expectation.
    always @(negedge pclk) begin
        exp_t e;
        if (bus.rsp_valid === 1'b1) begin
            n_checks++;
            assert (sb.size() != 0) else begin
                n_fail++;
                $error("FAIL rsp_unexpected: observed rsp_valid=1 expected no response");
            end
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("rsp_err", 64'(bus.rsp_err), 64'(e.err));
                check("rsp_rdata", 64'(bus.rsp_rdata), 64'(e.rdata));
                check("rsp_latency", 64'(cyc - e.issue_cyc), 64'(e.lat));
            end
        end
        if (bus3.rsp_valid === 1'b1) begin
            n_checks++;
            assert (sb3.size() != 0) else begin
                n_fail++;
                $error("FAIL rsp3_unexpected: observed rsp_valid=1 expected no response");
            end
            if (sb3.size() != 0) begin
                e = sb3.pop_front();
                check("rsp3_err", 64'(bus3.rsp_err), 64'(e.err));
                check("rsp3_rdata", 64'(bus3.rsp_rdata), 64'(e.rdata));
                check("rsp3_latency", 64'(cyc - e.issue_cyc), 64'(e.lat));
            end
        end
    end

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic issue(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                         input logic e_err, input logic [DW-1:0] e_rd, input int lat);
        exp_t e;
        int   n = 0;
        while (bus.req_ready !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        check("req_ready", 64'(bus.req_ready), 64'(1'b1));
        bus.req_valid = 1'b1;
        bus.req_write = wr;
        bus.req_addr  = addr;
        bus.req_wdata = wd;
        e.err = e_err; e.rdata = e_rd; e.issue_cyc = cyc; e.lat = lat;
        sb.push_back(e);
        last_issue = cyc;
        tick();
        bus.req_valid = 1'b0;
    endtask

    task automatic issue3(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                          input logic e_err, input logic [DW-1:0] e_rd, input int lat);
        exp_t e;
        int   n = 0;
        while (bus3.req_ready !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        check("req3_ready", 64'(bus3.req_ready), 64'(1'b1));
        bus3.req_valid = 1'b1;
        bus3.req_write = wr;
        bus3.req_addr  = addr;
        bus3.req_wdata = wd;
        e.err = e_err; e.rdata = e_rd; e.issue_cyc = cyc; e.lat = lat;
        sb3.push_back(e);
        tick();
        bus3.req_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int max_cyc);
        int n = 0;
        while (bus.rsp_valid !== 1'b1 && n < max_cyc) begin
            tick();
            n++;
        end
        check("rsp_arrived", 64'(bus.rsp_valid), 64'(1'b1));
    endtask

    initial begin
        int a;
        int acc;
        rst = 1'b1;
        bus.req_valid  = 1'b0; bus.req_write  = 1'b0; bus.req_addr  = '0; bus.req_wdata  = '0;
        bus3.req_valid = 1'b0; bus3.req_write = 1'b0; bus3.req_addr = '0; bus3.req_wdata = '0;
        bus.prdata  = '0; bus.pslverr  = '0;
        bus3.prdata = '0; bus3.pslverr = '0;
        pready3 = '0;
        wait_n[0] = 0; wait_n[1] = 0;
        #2 rst = 1'b0;
        #1;
        // Reset state
        check("rst_psel", 64'(bus.psel), 64'(2'b00));
        check("rst_penable", 64'(bus.penable), 64'(1'b0));
        check("rst_pwrite", 64'(bus.pwrite), 64'(1'b0));
        check("rst_paddr", 64'(bus.paddr), 64'(5'h00));
        check("rst_pwdata", 64'(bus.pwdata), 64'(32'h0));
        check("rst_rsp_valid", 64'(bus.rsp_valid), 64'(1'b0));
        check("rst_rsp_rdata", 64'(bus.rsp_rdata), 64'(32'h0));
        check("rst_rsp_err", 64'(bus.rsp_err), 64'(1'b0));
        check("rst_req_ready", 64'(bus.req_ready), 64'(1'b1));
        repeat (2) @(posedge pclk);
        #3 rst = 1'b1;
        tick();

        // 1. Zero-wait write to slave 0
        issue(1'b1, 5'h02, 32'hA5A5_0001, 1'b0, 32'h0, 3);
        check("t1_setup_psel", 64'(bus.psel), 64'(2'b01));
        check("t1_setup_penable", 64'(bus.penable), 64'(1'b0));
        check("t1_pwrite", 64'(bus.pwrite), 64'(1'b1));
        check("t1_paddr", 64'(bus.paddr), 64'(5'h02));
        check("t1_pwdata", 64'(bus.pwdata), 64'(32'hA5A5_0001));
        tick();
        check("t1_access_psel", 64'(bus.psel), 64'(2'b01));
        check("t1_access_penable", 64'(bus.penable), 64'(1'b1));
        tick();
        check("t1_rsp_valid", 64'(bus.rsp_valid), 64'(1'b1));
        check("t1_idle_psel", 64'(bus.psel), 64'(2'b00));
        check("t1_idle_penable", 64'(bus.penable), 64'(1'b0));

        // 2. Read from slave 1 with three wait states
        wait_n[1] = 3;
        bus.prdata = {32'hDEAD_BEEF, 32'h1111_1111};
        issue(1'b0, 5'h11, 32'h0BAD_0BAD, 1'b0, 32'hDEAD_BEEF, 6);
        repeat (4) tick();
        check("t2_last_access_psel", 64'(bus.psel), 64'(2'b10));
        check("t2_last_access_penable", 64'(bus.penable), 64'(1'b1));
        check("t2_paddr_stable", 64'(bus.paddr), 64'(5'h11));
        check("t2_pwrite_stable", 64'(bus.pwrite), 64'(1'b0));
        wait_rsp(10);
        tick();
        check("t2_rsp_pulse_ends", 64'(bus.rsp_valid), 64'(1'b0));
        check("t2_rsp_rdata_hold", 64'(bus.rsp_rdata), 64'(32'hDEAD_BEEF));

        // 3. pslverr on slave 1; slave 0 is unaffected by slave 1's error line
        wait_n[1] = 0;
        bus.pslverr = 2'b10;
        issue(1'b0, 5'h13, 32'h0, 1'b1, 32'h0, 3);
        wait_rsp(10);
        issue(1'b0, 5'h04, 32'h0, 1'b0, 32'h1111_1111, 3);
        wait_rsp(10);
        bus.pslverr = 2'b00;

        // 4. Timeout: slave 1 never ready while slave 0's pready stays high
        wait_n[1] = NEVER;
        issue(1'b0, 5'h11, 32'h0, 1'b1, 32'h0, 18);
        acc = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.psel[1] === 1'b1 && bus.penable === 1'b1) acc++;
            else if (acc > 0) break;
            tick();
        end
        check("t4_access_cycles", 64'(acc), 64'(16));
        check("t4_psel_released", 64'(bus.psel), 64'(2'b00));
        check("t4_rsp_valid", 64'(bus.rsp_valid), 64'(1'b1));
        wait_n[1] = 0;
        tick();

        // 5. Decode miss on the three-slave bridge, then an unbounded wait
        issue3(1'b1, 5'h18, 32'h0000_1234, 1'b1, 32'h0, 1);
        check("t5_miss_psel", 64'(bus3.psel), 64'(3'b000));
        check("t5_miss_penable", 64'(bus3.penable), 64'(1'b0));
        check("t5_miss_rsp_valid", 64'(bus3.rsp_valid), 64'(1'b1));
        check("t5_miss_rsp_err", 64'(bus3.rsp_err), 64'(1'b1));
        bus3.prdata = {32'hCAFE_F00D, 32'h2222_2222, 32'h3333_3333};
        issue3(1'b0, 5'h10, 32'h0, 1'b0, 32'hCAFE_F00D, 42);
        repeat (40) tick();
        check("t5_no_timeout_psel", 64'(bus3.psel), 64'(3'b100));
        check("t5_no_timeout_penable", 64'(bus3.penable), 64'(1'b1));
        pready3 = 3'b100;
        tick();
        check("t5_late_rsp_valid", 64'(bus3.rsp_valid), 64'(1'b1));
        pready3 = 3'b000;
        tick();

        // 6a. Back-to-back transfers
        issue(1'b1, 5'h03, 32'h0000_00B1, 1'b0, 32'h0, 3);
        a = last_issue;
        issue(1'b0, 5'h1C, 32'h0, 1'b0, 32'hDEAD_BEEF, 3);
        check("t6_b2b_spacing", 64'(last_issue - a), 64'(3));
        wait_rsp(10);
        tick();

        // 6b. Reset during ACCESS aborts the transfer with no response
        wait_n[1] = NEVER;
        issue(1'b1, 5'h15, 32'hFFFF_0000, 1'b0, 32'h0, 0);
        tick();
        check("t6_in_access", 64'(bus.penable), 64'(1'b1));
        sb.delete();
        #2 rst = 1'b0;
        #1;
        check("t6_rst_psel", 64'(bus.psel), 64'(2'b00));
        check("t6_rst_penable", 64'(bus.penable), 64'(1'b0));
        check("t6_rst_pwrite", 64'(bus.pwrite), 64'(1'b0));
        check("t6_rst_paddr", 64'(bus.paddr), 64'(5'h00));
        check("t6_rst_pwdata", 64'(bus.pwdata), 64'(32'h0));
        check("t6_rst_rsp_valid", 64'(bus.rsp_valid), 64'(1'b0));
        check("t6_rst_rsp_rdata", 64'(bus.rsp_rdata), 64'(32'h0));
        repeat (2) @(posedge pclk);
        #3 rst = 1'b1;
        wait_n[1] = 0;
        repeat (3) tick();
        check("t6_post_rst_rsp_valid", 64'(bus.rsp_valid), 64'(1'b0));
        check("t6_post_rst_req_ready", 64'(bus.req_ready), 64'(1'b1));

        check("sb_drained", 64'(sb.size() + sb3.size()), 64'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
